// File: rtl/min_tau_pkg.sv
// Shared FSM encoding and derived-width helpers for the min-tau period detector.
package min_tau_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        EVAL  = 2'd1,
        DONE  = 2'd2
    } state_t;

    // min_tau is an 8-bit port and MAX_TAU is capped at 255, so 8 bits covers every lag.
    localparam int TAU_W = 8;

    function automatic int win_len(input int bits);
        return 1 << bits;
    endfunction

    function automatic int prod_w(input int iw);
        return 2 * iw;
    endfunction

    function automatic int idx_w(input int n, input int max_tau);
        return $clog2(n + max_tau);
    endfunction

endpackage

// File: rtl/min_tau_sqdiff_acc.sv
// Accumulates (a-b)^2 for one lag, one sample pair per clock; d is the running sum.
// Latency: each term lands in d one clock after en. Backpressure: none, driven by the FSM.
// clr has priority over en and zeroes the sum for the next lag.
module min_tau_sqdiff_acc
    import min_tau_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  d
);
    localparam int SQ_W = 2 * DATA_WIDTH + 2;

    logic signed [DATA_WIDTH:0] diff;
    logic signed [SQ_W-1:0]     diff_x;
    logic signed [SQ_W-1:0]     sq;

    assign diff   = $signed({1'b0, a}) - $signed({1'b0, b});
    assign diff_x = SQ_W'(diff);
    assign sq     = diff_x * diff_x;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            d <= '0;
        end else if (en) begin
            d <= d + ACC_WIDTH'($unsigned(sq));
        end
    end

endmodule

// File: rtl/min_tau_module.sv
// Period detector: scans lags 1..MAX_TAU-1 with a CMNDF threshold/descent rule, global-min fallback.
// Latency (MAX_TAU-1)*(N+1) clocks, shorter with MIN_TAU_EARLY_EXIT_EN defined (stops when descent ends).
// Backpressure: none; data must stay stable until ready, which then holds until reset.
module min_tau_module
    import min_tau_pkg::*;
#(
    parameter int WINDOW_SIZE_BITS        = 8,
    parameter int DATA_WIDTH              = 8,
    parameter int MAX_TAU                 = 40,
    parameter int INTERMEDIATE_DATA_WIDTH = 64,
    parameter int THRESHOLD               = 1,
    parameter int THRESHOLD_FRAC_BITS     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data [0:(1 << WINDOW_SIZE_BITS) + MAX_TAU - 1],
    output logic                  ready,
    output logic [7:0]            min_tau
);
    localparam int N     = win_len(WINDOW_SIZE_BITS);
    localparam int IW    = INTERMEDIATE_DATA_WIDTH;
    localparam int PW    = prod_w(IW);
    localparam int IDX_W = idx_w(N, MAX_TAU);
    localparam logic [TAU_W-1:0]            LAST_TAU = TAU_W'(MAX_TAU - 1);
    localparam logic [WINDOW_SIZE_BITS-1:0] LAST_J   = '1;

    state_t                      state, state_nxt;
    logic [TAU_W-1:0]            tau, cand_tau, best_tau, cand_nxt, best_nxt, final_tau;
    logic [WINDOW_SIZE_BITS-1:0] j;
    logic [IW-1:0]               d_val, s_sum, s_new, num, num_prev, best_num, best_s;
    logic                        descending, locked, below, rise, better, desc_start, desc_end;
    logic [IDX_W-1:0]            idx_a, idx_b;

    assign idx_a = IDX_W'(j);
    assign idx_b = IDX_W'(j) + IDX_W'(tau);

    min_tau_sqdiff_acc #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (IW)
    ) u_acc (
        .clk  (clk),
        .reset(reset),
        .clr  (state == EVAL),
        .en   (state == ACCUM),
        .a    (data[idx_a]),
        .b    (data[idx_b]),
        .d    (d_val)
    );

    // Ratios num/S are compared by cross-multiplication, so no divider is needed.
    always_comb begin
        s_new      = s_sum + d_val;
        num        = IW'(PW'(tau) * PW'(d_val));
        below      = (s_new != '0) &&
                     ((PW'(num) << THRESHOLD_FRAC_BITS) < (PW'(THRESHOLD) * PW'(s_new)));
        rise       = (PW'(num) * PW'(s_sum)) >= (PW'(num_prev) * PW'(s_new));
        better     = (PW'(num) * PW'(best_s)) < (PW'(best_num) * PW'(s_new));
        desc_start = !descending && below;
        desc_end   = descending && !locked && rise;

        cand_nxt = cand_tau;
        if (desc_start || (descending && !locked && !rise)) begin
            cand_nxt = tau;
        end
        best_nxt = best_tau;
        if ((tau == TAU_W'(1)) || better) begin
            best_nxt = tau;
        end
        final_tau = (descending || desc_start) ? cand_nxt : best_nxt;

        state_nxt = state;
        case (state)
            ACCUM: begin
                if (j == LAST_J) state_nxt = EVAL;
            end
            EVAL: begin
                if (tau == LAST_TAU) state_nxt = DONE;
`ifdef MIN_TAU_EARLY_EXIT_EN
                else if (desc_end) state_nxt = DONE;
`endif
                else state_nxt = ACCUM;
            end
            default: state_nxt = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ACCUM;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tau        <= TAU_W'(1);
            j          <= '0;
            s_sum      <= '0;
            num_prev   <= '0;
            best_num   <= '0;
            best_s     <= '0;
            best_tau   <= '0;
            cand_tau   <= '0;
            descending <= 1'b0;
            locked     <= 1'b0;
            ready      <= 1'b0;
            min_tau    <= '0;
        end else begin
            case (state)
                ACCUM: j <= j + WINDOW_SIZE_BITS'(1);
                EVAL: begin
                    j        <= '0;
                    s_sum    <= s_new;
                    num_prev <= num;
                    cand_tau <= cand_nxt;
                    best_tau <= best_nxt;
                    if ((tau == TAU_W'(1)) || better) begin
                        best_num <= num;
                        best_s   <= s_new;
                    end
                    if (desc_start) descending <= 1'b1;
                    // Once the descent ends the result is frozen even if the scan continues.
                    if (desc_end) locked <= 1'b1;
                    if (state_nxt == DONE) begin
                        ready   <= 1'b1;
                        min_tau <= final_tau;
                    end else begin
                        tau <= tau + TAU_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_min_tau_module.sv
// Scoreboard bench: two instances (THRESHOLD=1 and THRESHOLD=0) share frames and reset.
module tb_min_tau_module;
    localparam int N   = 256;
    localparam int MT  = 40;
    localparam int LEN = N + MT;
    localparam int FULL_LAT = (MT - 1) * (N + 1);

    typedef struct {
        int tau;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] frame [0:LEN-1];
    logic       rdy_a, rdy_b;
    logic [7:0] tau_a, tau_b;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t pop_a, pop_b;
    logic prev_a = 1'b0, prev_b = 1'b0;
    logic [7:0] hold_a, hold_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    min_tau_module #(
        .WINDOW_SIZE_BITS(8), .DATA_WIDTH(8), .MAX_TAU(MT),
        .INTERMEDIATE_DATA_WIDTH(64), .THRESHOLD(1), .THRESHOLD_FRAC_BITS(0)
    ) dut_a (
        .clk(clk), .reset(reset), .data(frame), .ready(rdy_a), .min_tau(tau_a)
    );

    min_tau_module #(
        .WINDOW_SIZE_BITS(8), .DATA_WIDTH(8), .MAX_TAU(MT),
        .INTERMEDIATE_DATA_WIDTH(64), .THRESHOLD(0), .THRESHOLD_FRAC_BITS(0)
    ) dut_b (
        .clk(clk), .reset(reset), .data(frame), .ready(rdy_b), .min_tau(tau_b)
    );

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: d, S and d' straight from their definitions, ratios compared exactly.
    function automatic int model(input longint thr);
        longint d[MT];
        longint s[MT];
        longint acc;
        longint df;
        int     c, best;
        acc = 0;
        for (int t = 1; t < MT; t++) begin
            d[t] = 0;
            for (int k = 0; k < N; k++) begin
                df   = longint'(frame[k]) - longint'(frame[k + t]);
                d[t] += df * df;
            end
            acc  += d[t];
            s[t] = acc;
        end
        for (int t = 1; t < MT; t++) begin
            if (s[t] != 0 && longint'(t) * d[t] < thr * s[t]) begin
                c = t;
                while (c < MT - 1 &&
                       longint'(c + 1) * d[c + 1] * s[c] < longint'(c) * d[c] * s[c + 1])
                    c++;
                return c;
            end
        end
        best = 1;
        for (int t = 2; t < MT; t++) begin
            if (longint'(t) * d[t] * s[best] < longint'(best) * d[best] * s[t]) best = t;
        end
        return best;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            prev_a <= 1'b0;
        end else if (rdy_a && !prev_a) begin
            prev_a <= 1'b1;
            hold_a <= tau_a;
            if (q_a.size() == 0) begin
                check("unexpected_ready_a", 1, 0);
            end else begin
                pop_a = q_a.pop_front();
                check("min_tau_a", int'(tau_a), pop_a.tau);
                if (pop_a.lat >= 0) check("latency_a", cyc - start_cyc, pop_a.lat);
            end
        end else if (prev_a) begin
            check("hold_ready_a", int'(rdy_a), 1);
            check("hold_tau_a", int'(tau_a), int'(hold_a));
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_b <= 1'b0;
        end else if (rdy_b && !prev_b) begin
            prev_b <= 1'b1;
            hold_b <= tau_b;
            if (q_b.size() == 0) begin
                check("unexpected_ready_b", 1, 0);
            end else begin
                pop_b = q_b.pop_front();
                check("min_tau_b", int'(tau_b), pop_b.tau);
                if (pop_b.lat >= 0) check("latency_b", cyc - start_cyc, pop_b.lat);
            end
        end else if (prev_b) begin
            check("hold_ready_b", int'(rdy_b), 1);
            check("hold_tau_b", int'(tau_b), int'(hold_b));
        end
    end

    task automatic fill(input int kind);
        int p;
        p = $urandom_range(4, 30);
        for (int n = 0; n < LEN; n++) begin
            case (kind)
                0: frame[n] = 8'd128;
                1: frame[n] = ((n % 10) < 5) ? 8'd0 : 8'd255;
                2: frame[n] = 8'($rtoi(127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * 105.26 * n / 2000.0) + 0.5));
                3: frame[n] = 8'($urandom_range(0, 255));
                default: frame[n] = 8'(((n % p) * 200) / p + int'($urandom_range(0, 55)));
            endcase
        end
    endtask

    task automatic run_frame(input int kind, input bit mid_reset, input int fix_a, input int fix_b);
        exp_t ea, eb;
        int   n;
        @(negedge clk);
        #1;
        reset = 1'b1;
        fill(kind);
        ea.tau = (fix_a >= 0) ? fix_a : model(1);
        eb.tau = (fix_b >= 0) ? fix_b : model(0);
`ifdef MIN_TAU_EARLY_EXIT_EN
        ea.lat = -1;
`else
        ea.lat = FULL_LAT;
`endif
        eb.lat = FULL_LAT;
        @(negedge clk);
        check("reset_ready_a", int'(rdy_a), 0);
        check("reset_tau_a", int'(tau_a), 0);
        check("reset_ready_b", int'(rdy_b), 0);
        check("reset_tau_b", int'(tau_b), 0);
        q_a.push_back(ea);
        q_b.push_back(eb);
        #1;
        reset     = 1'b0;
        start_cyc = cyc;
        if (mid_reset) begin
            repeat (3000) @(negedge clk);
            #1;
            reset = 1'b1;
            @(negedge clk);
            check("midrst_ready_a", int'(rdy_a), 0);
            check("midrst_tau_a", int'(tau_a), 0);
            check("midrst_ready_b", int'(rdy_b), 0);
            check("midrst_tau_b", int'(tau_b), 0);
            #1;
            reset     = 1'b0;
            start_cyc = cyc;
        end
        n = 0;
        while (!(rdy_a === 1'b1 && rdy_b === 1'b1) && n < FULL_LAT + 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(rdy_a === 1'b1 && rdy_b === 1'b1)) begin
            check("ready_timeout", 0, 1);
            q_a.delete();
            q_b.delete();
        end
        repeat (100) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        for (int n = 0; n < LEN; n++) frame[n] = 8'd0;
        repeat (2) @(negedge clk);
        run_frame(0, 1'b0, 1, 1);
        run_frame(1, 1'b0, 10, -1);
        run_frame(2, 1'b1, 19, 19);
        run_frame(3, 1'b0, -1, -1);
        for (int f = 0; f < 3; f++) run_frame(4, 1'b0, -1, -1);
        repeat (5) @(negedge clk);
        check("sb_drain_a", q_a.size(), 0);
        check("sb_drain_b", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/min_tau_module.md
MIN_TAU_MODULE -- requirements
Module: min_tau_module

Interface
REQ-001 SHALL have parameter WINDOW_SIZE_BITS, default 8: analysis window N = 2**WINDOW_SIZE_BITS samples.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: unsigned sample width.
REQ-003 SHALL have parameter MAX_TAU, default 40: lags scanned are 1..MAX_TAU-1; legal range 2..255.
REQ-004 SHALL have parameter INTERMEDIATE_DATA_WIDTH, default 64: width of the difference accumulator and running sum.
REQ-005 SHALL have parameter THRESHOLD, default 1: numerator of the CMNDF threshold.
REQ-006 SHALL have parameter THRESHOLD_FRAC_BITS, default 0: threshold value = THRESHOLD / 2**THRESHOLD_FRAC_BITS.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port data, input, unpacked array [0 : N+MAX_TAU-1] of DATA_WIDTH: sample frame, held stable by the caller until ready.
REQ-010 SHALL have port ready, output, 1 bit: min_tau is valid.
REQ-011 SHALL have port min_tau, output, 8 bits: detected period in samples.

Function
REQ-012 SHALL compute d(tau) = sum over j=0..N-1 of (data[j]-data[j+tau])**2, with the difference taken signed and the square unsigned, one term per clock.
REQ-013 SHALL keep the running sum S(tau) = d(1)+...+d(tau).
REQ-014 SHALL define CMNDF d'(tau) = tau*d(tau)/S(tau) and evaluate it without division, by cross-multiplication.
REQ-015 d'(tau) < threshold SHALL be tested as (tau*d(tau)) << THRESHOLD_FRAC_BITS < THRESHOLD*S(tau); when S=0 the test is false.
REQ-016 SHALL use FSM states ACCUM (N cycles per tau), EVAL (1 cycle per tau) and DONE.
REQ-017 Reset SHALL enter ACCUM with tau=1 and j=0.
REQ-018 On j=N-1 the FSM SHALL go to EVAL.
REQ-019 EVAL SHALL update S, the best-tau trackers and the decision, then go to ACCUM with tau+1, or to DONE.
REQ-020 Result selection: the first tau with d'(tau) below threshold SHALL start a descent; the result is the last tau before d'(tau+1) >= d'(tau), or MAX_TAU-1 if the descent does not end.
REQ-021 If no tau crosses the threshold, the result SHALL be the tau with the global minimum d'; on ties the smallest tau wins (strict less-than cross-multiplied compare).
REQ-022 Entering DONE SHALL register min_tau and set ready=1 on the same edge.
REQ-023 In DONE, ready and min_tau SHALL hold until reset; no restart without reset.
REQ-024 Internal products SHALL be 2*INTERMEDIATE_DATA_WIDTH wide with no truncation.
REQ-025 Integrator responsibility: INTERMEDIATE_DATA_WIDTH >= 2*DATA_WIDTH+WINDOW_SIZE_BITS+8.
REQ-026 Constant input SHALL give d=0 for every tau, hence min_tau=1.

Reset
REQ-027 While reset is high: ready=0, min_tau=0, accumulators=0, tau=1, j=0, state=ACCUM.
REQ-028 Reset asserted mid-computation SHALL abort and restart from tau=1 on the first edge with reset low.

Configuration
REQ-029 SHALL compile early exit in or out with macro MIN_TAU_EARLY_EXIT_EN.
REQ-030 With MIN_TAU_EARLY_EXIT_EN defined: the FSM SHALL enter DONE at the EVAL where the REQ-020 descent ends.
REQ-031 Without MIN_TAU_EARLY_EXIT_EN: all taus SHALL always be scanned, and ready SHALL rise exactly (MAX_TAU-1)*(N+1) rising edges after the first edge with reset low.
REQ-032 min_tau SHALL be identical in both builds.

Structure
REQ-033 Package min_tau_pkg SHALL hold the FSM state enum and the derived-width constants (N, tau counter width, product width).
REQ-034 Sub-module min_tau_sqdiff_acc SHALL perform the per-tau squared-difference accumulation (sample pair in, clear/enable, d out); the FSM and compare logic SHALL stay in the top module.

Verification
REQ-035 Sine 105.26 Hz at fs=2000, scaled 0..255, defaults -> ready rises, min_tau=19.
REQ-036 Constant 128 in all samples -> min_tau=1; without MIN_TAU_EARLY_EXIT_EN, ready rises after 10023 edges.
REQ-037 Square wave with period 10 (0/255, 5 samples each) -> min_tau=10 in both builds.
REQ-038 Reset pulsed at cycle 3000 -> ready=0 and min_tau=0 the next cycle; the result after restart equals an uninterrupted run.
REQ-039 THRESHOLD=0 on the sine stimulus -> global-minimum fallback, min_tau=19, ready after the full scan.
REQ-040 Hold ready=1 for 100 cycles after DONE -> min_tau stable and ready does not drop.
